// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module id_ex_skid_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_rd1,
    input  logic [DATA_W-1:0]  in_rd2,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic               in_data_s,
    input  logic               in_we,
    input  logic [RADDR_W-1:0] in_wsel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_rd1,
    output logic [DATA_W-1:0]  out_rd2,
    output logic [DATA_W-1:0]  out_imm,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_data_s,
    output logic               out_we,
    output logic [RADDR_W-1:0] out_wsel,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam int PW = 3 * DATA_W + ALUOP_W + 2 + RADDR_W;
    logic [PW-1:0]    w_in;
    logic [PW-1:0]    r_main;
    logic [PW-1:0]    r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_free;
    logic             w_main_we;
    assign w_in        = {in_rd1, in_rd2, in_imm, in_aluop, in_data_s, in_we, in_wsel};
    assign in_ready    = ~r_skid_valid;
    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = r_main_valid & out_ready;
    assign w_main_free = ~r_main_valid | w_out_fire;
    assign {out_rd1, out_rd2, out_imm, out_aluop, out_data_s, w_main_we, out_wsel} = r_main;
    assign out_valid   = r_main_valid;
    assign out_we      = w_main_we & r_main_valid;
    assign stall_cnt   = r_stall_cnt;
    // skid never coexists with an accepted input, so the skid-to-main move and in_fire are exclusive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
            r_stall_cnt  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else begin
            if (w_main_free) begin
                r_main_valid <= r_skid_valid | w_in_fire;
                r_skid_valid <= 1'b0;
                if (r_skid_valid)
                    r_main <= r_skid;
                else if (w_in_fire)
                    r_main <= w_in;
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid       <= w_in;
            end
            if (r_main_valid && !out_ready && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb_id_ex_skid_stage: randomized and directed checks of id_ex_skid_stage against a queue-based model.
module tb_id_ex_skid_stage;
    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [2:0]  aluop;
        logic        ds;
        logic        we;
        logic [4:0]  wsel;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    ins_t din = '0;

    logic        in_ready, out_valid, out_data_s, out_we;
    logic [31:0] out_rd1, out_rd2, out_imm;
    logic [2:0]  out_aluop;
    logic [4:0]  out_wsel;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, out_data_s2, out_we2;
    logic [31:0] out_rd12, out_rd22, out_imm2;
    logic [2:0]  out_aluop2;
    logic [4:0]  out_wsel2;
    logic [3:0]  stall_cnt2;

    ins_t q[$];
    ins_t m_last = '0;
    int   m_cnt = 0;
    int   m_cnt4 = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd1(din.rd1), .in_rd2(din.rd2), .in_imm(din.imm), .in_aluop(din.aluop),
        .in_data_s(din.ds), .in_we(din.we), .in_wsel(din.wsel),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_imm(out_imm), .out_aluop(out_aluop), .out_data_s(out_data_s), .out_we(out_we),
        .out_wsel(out_wsel), .stall_cnt(stall_cnt)
    );

    id_ex_skid_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_rd1(din.rd1), .in_rd2(din.rd2), .in_imm(din.imm), .in_aluop(din.aluop),
        .in_data_s(din.ds), .in_we(din.we), .in_wsel(din.wsel),
        .out_valid(out_valid2), .out_ready(out_ready), .out_rd1(out_rd12), .out_rd2(out_rd22),
        .out_imm(out_imm2), .out_aluop(out_aluop2), .out_data_s(out_data_s2), .out_we(out_we2),
        .out_wsel(out_wsel2), .stall_cnt(stall_cnt2)
    );

    function automatic ins_t rnd_ins();
        ins_t r;
        r.rd1   = $urandom;
        r.rd2   = $urandom;
        r.imm   = $urandom;
        r.aluop = 3'($urandom);
        r.ds    = 1'($urandom);
        r.we    = 1'($urandom);
        r.wsel  = 5'($urandom);
        return r;
    endfunction

    function automatic ins_t out_ins();
        return {out_rd1, out_rd2, out_imm, out_aluop, out_data_s, out_we, out_wsel};
    endfunction

    function automatic logic [127:0] got_vec();
        return {out_valid, in_ready, out_rd1, out_rd2, out_imm, out_aluop, out_data_s, out_we,
                out_wsel, stall_cnt, stall_cnt2};
    endfunction

    function automatic logic [127:0] exp_vec();
        ins_t e = m_last;
        e.we = e.we & (q.size() > 0);
        return {q.size() > 0, q.size() < 2, e, m_cnt[15:0], m_cnt4[3:0]};
    endfunction

    // Stage behaves as a 2-deep FIFO: front is presented, accept only while not full.
    task automatic step();
        int sz;
        @(posedge clk);
        sz = q.size();
        if (rst) begin
            q.delete();
            m_last = '0;
            m_cnt = 0;
            m_cnt4 = 0;
        end else if (flush) begin
            q.delete();
            m_last = '0;
        end else begin
            if (sz > 0 && !out_ready) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (sz > 0 && out_ready) void'(q.pop_front());
            if (in_valid && sz < 2) q.push_back(din);
            if (q.size() > 0) m_last = q[0];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        step(); step();
        n_cmp++;
        if (got_vec() !== {1'b0, 1'b1, 126'b0}) begin
            n_fail++; $display("FAIL reset_state: got %h exp %h", got_vec(), {1'b0, 1'b1, 126'b0});
        end
        rst = 0; in_valid = 1; out_ready = 1;
        din = {32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 1'b1, 5'd7};
        n_cmp++;
        if (got_vec() !== {1'b0, 1'b1, 126'b0}) begin
            n_fail++; $display("FAIL pre_first: got %h exp %h", got_vec(), {1'b0, 1'b1, 126'b0});
        end
        step();
        in_valid = 0;
        n_cmp++;
        if ({out_valid, out_ins()} !== {1'b1, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 1'b1, 5'd7}) begin
            n_fail++; $display("FAIL first_instr: got %h exp %h", {out_valid, out_ins()},
                               {1'b1, 32'h11, 32'h22, 32'h33, 3'b010, 1'b1, 1'b1, 5'd7});
        end
        step();
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL first_drain: got %h exp %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        ins_t sent[8];
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            sent[i] = rnd_ins();
            din = sent[i];
            in_valid = 1;
            step();
            n_cmp++;
            if (out_valid !== 1'b1 || out_ins() !== sent[i] || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
                n_fail++; $display("FAIL b2b_order[%0d]: got v=%b r=%b cnt=%0d %h exp v=1 r=1 cnt=0 %h",
                                   i, out_valid, in_ready, stall_cnt, out_ins(), sent[i]);
            end
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_model[%0d]: got %h exp %h", i, got_vec(), exp_vec());
            end
        end
        in_valid = 0;
        step();
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL b2b_empty: got %h exp %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_stall_skid();
        ins_t a, b, c;
        ins_t seen[$];
        a = rnd_ins(); b = rnd_ins(); c = rnd_ins();
        out_ready = 0; in_valid = 1; din = a;
        step();
        din = b;
        step();
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ins() !== a) begin
            n_fail++; $display("FAIL skid_full: got r=%b v=%b %h exp r=0 v=1 %h", in_ready, out_valid, out_ins(), a);
        end
        din = c;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (got_vec() !== exp_vec() || out_ins() !== a || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (stall_cnt !== 16'd5) begin
            n_fail++; $display("FAIL stall_count: got %0d exp 5", stall_cnt);
        end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen.push_back(out_ins());
            if (in_valid && in_ready) begin
                step();
                in_valid = 0;
            end else step();
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL drain_model[%0d]: got %h exp %h", i, got_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (seen.size() != 3 || seen[0] !== a || seen[1] !== b || seen[2] !== c) begin
            n_fail++; $display("FAIL drain_order: got %0d items exp 3 in order A,B,C", seen.size());
        end
    endtask

    task automatic test_flush();
        ins_t x;
        out_ready = 0; in_valid = 1; din = rnd_ins();
        step();
        din = rnd_ins();
        step();
        x = rnd_ins();
        din = x; flush = 1;
        step();
        flush = 0; in_valid = 0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_we !== 1'b0 || in_ready !== 1'b1 ||
            {out_rd1, out_rd2, out_imm, out_aluop, out_data_s, out_wsel} !== 105'b0) begin
            n_fail++; $display("FAIL flush_clear: got %h exp %h", got_vec(), exp_vec());
        end
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL flush_model: got %h exp %h", got_vec(), exp_vec());
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || out_rd1 === x.rd1) begin
                n_fail++; $display("FAIL flushed_gone[%0d]: got v=%b rd1=%h exp v=0", i, out_valid, out_rd1);
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1;
        step();
        rst = 0; out_ready = 0; in_valid = 1; din = rnd_ins();
        step();
        in_valid = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_cmp++;
            if (stall_cnt2 !== 4'((i > 15) ? 15 : i) || stall_cnt !== 16'(i)) begin
                n_fail++; $display("FAIL sat_count[%0d]: got %0d/%0d exp %0d/%0d", i, stall_cnt2, stall_cnt,
                                   (i > 15) ? 15 : i, i);
            end
        end
        rst = 1;
        step();
        rst = 0;
        n_cmp++;
        if (stall_cnt2 !== 4'd0 || stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL sat_clear: got %0d/%0d exp 0/0", stall_cnt2, stall_cnt);
        end
    endtask

    task automatic test_rst_mid_stall();
        ins_t y;
        out_ready = 0; in_valid = 1; din = rnd_ins();
        step();
        din = rnd_ins();
        step(); step(); step();
        rst = 1;
        step();
        rst = 0; in_valid = 0;
        n_cmp++;
        if (got_vec() !== {1'b0, 1'b1, 126'b0}) begin
            n_fail++; $display("FAIL rst_mid: got %h exp %h", got_vec(), {1'b0, 1'b1, 126'b0});
        end
        y = rnd_ins();
        din = y; in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_ins() !== {y.rd1, y.rd2, y.imm, y.aluop, y.ds, y.we, y.wsel}) begin
            n_fail++; $display("FAIL post_rst: got v=%b %h exp v=1 %h", out_valid, out_ins(), y);
        end
        step();
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL post_rst_drain: got %h exp %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            din       = rnd_ins();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d]: got %h exp %h", i, got_vec(), exp_vec());
            end
        end
        rst = 0; flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_skid();
        test_flush();
        test_saturation();
        test_rst_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
